// File: rtl/bd_rx_buffer_if.sv
// Host-side register bus of the BD receive buffer: single-cycle valid/ready
// request with registered read data.
interface bd_rx_buffer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              valid;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              ready;

  modport master (output valid, write, address, data_in, input data_out, ready);
  modport slave  (input valid, write, address, data_in, output data_out, ready);
endinterface

// File: rtl/bd_rx_buffer.sv
// Multi-channel receive buffer: one FIFO per decoder channel with
// status/threshold/control registers and a registered level interrupt.
module bd_rx_buffer #(
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 8
) (
  input  logic                       G_CLK_RX,
  input  logic                       reset,
  input  logic [CHANNELS-1:0]        dec_valid,
  input  logic [CHANNELS*DATA_W-1:0] dec_data,
  bd_rx_buffer_if.slave              bus,
  output logic                       int_rx_host
);
  localparam int PW = $clog2(DEPTH);

  logic              accept, rd, wr;
  logic [ADDR_W-3:0] reg_idx;
  logic [1:0]        reg_ofs;
  logic [DATA_W-1:0] rdata;

  // A request is ignored while the previous acknowledge is still high.
  assign accept  = bus.valid & ~bus.ready;
  assign rd      = accept & ~bus.write;
  assign wr      = accept & bus.write;
  assign reg_idx = bus.address[ADDR_W-1:2];
  assign reg_ofs = bus.address[1:0];

  logic [PW:0]       cnt_a    [CHANNELS];
  logic [DATA_W-1:0] head_a   [CHANNELS];
  logic [DATA_W-1:0] status_a [CHANNELS];
  logic [DATA_W-1:0] thresh_a [CHANNELS];
  logic [CHANNELS-1:0] en_a, int_en_a, cause;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     rptr, wptr;
    logic [PW:0]       cnt;
    logic [DATA_W-1:0] thresh;
    logic              en, int_en, ovf;
    logic              hit, pop, push, full, empty, flush, ovf_clr, ovf_evt;
    logic [31:0]       cnt32;
    logic [4:0]        cnt_sat;

    assign hit     = (reg_idx == (ADDR_W-2)'(g));
    assign full    = (cnt == (PW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign pop     = rd & hit & (reg_ofs == 2'd0) & ~empty;
    assign flush   = wr & hit & (reg_ofs == 2'd3) & bus.data_in[2];
    assign ovf_clr = wr & hit & (reg_ofs == 2'd3) & bus.data_in[3];
    // A push is only an overflow when it is lost to a full FIFO, not to a flush.
    assign ovf_evt = dec_valid[g] & en & full & ~pop & ~flush;
    assign push    = dec_valid[g] & en & (~full | pop) & ~flush;

    always_ff @(posedge G_CLK_RX) begin
      if (!reset) begin
        rptr   <= '0;
        wptr   <= '0;
        cnt    <= '0;
        thresh <= '0;
        en     <= 1'b0;
        int_en <= 1'b0;
        ovf    <= 1'b0;
      end else begin
        if (flush) begin
          rptr <= '0;
          wptr <= '0;
          cnt  <= '0;
        end else begin
          if (push) wptr <= wptr + 1'b1;
          if (pop)  rptr <= rptr + 1'b1;
          if (push & ~pop)      cnt <= cnt + 1'b1;
          else if (pop & ~push) cnt <= cnt - 1'b1;
        end
        ovf <= ovf_evt | (ovf & ~ovf_clr);
        if (wr & hit & (reg_ofs == 2'd2)) thresh <= bus.data_in;
        if (wr & hit & (reg_ofs == 2'd3)) begin
          en     <= bus.data_in[0];
          int_en <= bus.data_in[1];
        end
      end
    end

    always_ff @(posedge G_CLK_RX) begin
      if (push) mem[wptr] <= dec_data[g*DATA_W +: DATA_W];
    end

    assign cnt32       = 32'(cnt);
    assign cnt_sat     = (cnt32 > 32'd31) ? 5'd31 : cnt32[4:0];
    assign cnt_a[g]    = cnt;
    assign head_a[g]   = mem[rptr];
    assign status_a[g] = DATA_W'({cnt_sat, ovf, full, empty});
    assign thresh_a[g] = thresh;
    assign en_a[g]     = en;
    assign int_en_a[g] = int_en;
    assign cause[g]    = int_en & (((thresh != '0) && (cnt32 >= 32'(thresh))) | ovf);
  end

  always_comb begin
    rdata = '0;
    if (bus.address == ADDR_W'(8'hF0)) begin
      rdata = DATA_W'(cause);
    end else begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (reg_idx == (ADDR_W-2)'(c)) begin
          case (reg_ofs)
            2'd0:    rdata = (cnt_a[c] != '0) ? head_a[c] : '0;
            2'd1:    rdata = status_a[c];
            2'd2:    rdata = thresh_a[c];
            default: rdata = DATA_W'({int_en_a[c], en_a[c]});
          endcase
        end
      end
    end
  end

  always_ff @(posedge G_CLK_RX) begin
    if (!reset) begin
      bus.ready    <= 1'b0;
      bus.data_out <= '0;
      int_rx_host  <= 1'b0;
    end else begin
      bus.ready   <= accept;
      int_rx_host <= |cause;
      if (rd) bus.data_out <= rdata;
    end
  end
endmodule

// File: tb/tb_bd_rx_buffer.sv
// Directed self-checking bench for bd_rx_buffer (CHANNELS=2, DEPTH=16, DATA_W=8).
module tb_bd_rx_buffer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  dec_valid = '0;
  logic [15:0] dec_data = '0;
  logic        int_rx_host;
  int          tests = 0;
  int          fails = 0;

  bd_rx_buffer_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  bd_rx_buffer #(.DATA_W(8), .CHANNELS(2), .DEPTH(16), .ADDR_W(8)) dut (
    .G_CLK_RX    (clk),
    .reset       (reset),
    .dec_valid   (dec_valid),
    .dec_data    (dec_data),
    .bus         (bus),
    .int_rx_host (int_rx_host)
  );

  always #5 clk = ~clk;

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d, output logic ack);
    @(negedge clk);
    bus.valid = 1'b1; bus.write = 1'b0; bus.address = a;
    @(posedge clk); #1;
    bus.valid = 1'b0;
    ack = bus.ready;
    d   = bus.data_out;
    @(posedge clk);
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.valid = 1'b1; bus.write = 1'b1; bus.address = a; bus.data_in = d;
    @(posedge clk); #1;
    bus.valid = 1'b0; bus.write = 1'b0;
    @(posedge clk);
  endtask

  task automatic push(input int ch, input logic [7:0] d);
    @(negedge clk);
    dec_valid[ch] = 1'b1;
    dec_data[ch*8 +: 8] = d;
    @(posedge clk); #1;
    dec_valid = '0;
  endtask

  task automatic test_reset;
    logic [7:0] d; logic ack;
    reset = 1'b0; dec_valid = '1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({bus.ready, bus.data_out, int_rx_host} !== 10'h000) begin
      fails++;
      $display("FAIL reset_outputs: got ready=%b data_out=%h int=%b, want all 0",
               bus.ready, bus.data_out, int_rx_host);
    end
    dec_valid = '0;
    @(negedge clk); reset = 1'b1;
    bus_read(8'h01, d, ack);
    tests++;
    if (d !== 8'h01) begin fails++; $display("FAIL reset_status_ch0: got %h want 01", d); end
    bus_read(8'h05, d, ack);
    tests++;
    if (d !== 8'h01) begin fails++; $display("FAIL reset_status_ch1: got %h want 01", d); end
  endtask

  task automatic test_bus_timing;
    logic [7:0] d; logic ack, r1, r2, r3;
    bus_read(8'h80, d, ack);
    tests++;
    if (ack !== 1'b1 || d !== 8'h00) begin
      fails++; $display("FAIL unmapped_read: got ready=%b data=%h want 1/00", ack, d);
    end
    #1;
    tests++;
    if (bus.ready !== 1'b0) begin fails++; $display("FAIL ready_one_cycle: got %b want 0", bus.ready); end
    @(negedge clk);
    bus.valid = 1'b1; bus.write = 1'b0; bus.address = 8'h80;
    @(posedge clk); #1; r1 = bus.ready;
    @(posedge clk); #1; r2 = bus.ready;
    @(posedge clk); #1; r3 = bus.ready;
    bus.valid = 1'b0;
    @(posedge clk);
    tests++;
    if ({r1, r2, r3} !== 3'b101) begin
      fails++; $display("FAIL back_to_back_ready: got %b want 101", {r1, r2, r3});
    end
  endtask

  task automatic test_fill_drain;
    logic [7:0] d; logic ack;
    bus_write(8'h07, 8'h01);
    for (int i = 0; i < 16; i++) push(1, 8'(i));
    bus_read(8'h05, d, ack);
    tests++;
    if (d !== 8'h82) begin fails++; $display("FAIL full_status: got %h want 82", d); end
    push(1, 8'hAA);
    bus_read(8'h05, d, ack);
    tests++;
    if (d !== 8'h86) begin fails++; $display("FAIL overflow_status: got %h want 86", d); end
    for (int i = 0; i < 16; i++) begin
      bus_read(8'h04, d, ack);
      tests++;
      if (d !== 8'(i)) begin fails++; $display("FAIL drain_%0d: got %h want %h", i, d, 8'(i)); end
    end
    bus_read(8'h04, d, ack);
    tests++;
    if (d !== 8'h00) begin fails++; $display("FAIL empty_read: got %h want 00", d); end
    bus_read(8'h05, d, ack);
    tests++;
    if (d !== 8'h05) begin fails++; $display("FAIL drained_status: got %h want 05", d); end
    bus_write(8'h07, 8'h09);
    bus_read(8'h05, d, ack);
    tests++;
    if (d !== 8'h01) begin fails++; $display("FAIL ovf_clr_status: got %h want 01", d); end
  endtask

  task automatic test_wrap_simul;
    logic [7:0] d; logic ack;
    bus_write(8'h03, 8'h01);
    for (int i = 0; i < 10; i++) push(0, 8'h10 + 8'(i));
    for (int i = 0; i < 10; i++) begin
      bus_read(8'h00, d, ack);
      tests++;
      if (d !== 8'h10 + 8'(i)) begin fails++; $display("FAIL pre_wrap_%0d: got %h want %h", i, d, 8'h10 + 8'(i)); end
    end
    for (int i = 0; i < 16; i++) push(0, 8'h20 + 8'(i));
    bus_read(8'h01, d, ack);
    tests++;
    if (d !== 8'h82) begin fails++; $display("FAIL wrap_full_status: got %h want 82", d); end
    @(negedge clk);
    dec_valid[0] = 1'b1; dec_data[7:0] = 8'h30;
    bus.valid = 1'b1; bus.write = 1'b0; bus.address = 8'h00;
    @(posedge clk); #1;
    dec_valid = '0; bus.valid = 1'b0;
    tests++;
    if (bus.data_out !== 8'h20) begin fails++; $display("FAIL simul_pop: got %h want 20", bus.data_out); end
    @(posedge clk);
    bus_read(8'h01, d, ack);
    tests++;
    if (d !== 8'h82) begin fails++; $display("FAIL simul_status: got %h want 82", d); end
    for (int i = 0; i < 16; i++) begin
      bus_read(8'h00, d, ack);
      tests++;
      if (d !== 8'h21 + 8'(i)) begin fails++; $display("FAIL wrap_order_%0d: got %h want %h", i, d, 8'h21 + 8'(i)); end
    end
    bus_read(8'h01, d, ack);
    tests++;
    if (d !== 8'h01) begin fails++; $display("FAIL wrap_empty_status: got %h want 01", d); end
  endtask

  task automatic test_threshold;
    logic [7:0] d; logic ack;
    bus_write(8'h02, 8'h04);
    bus_write(8'h03, 8'h03);
    for (int i = 0; i < 4; i++) push(0, 8'h40 + 8'(i));
    tests++;
    if (int_rx_host !== 1'b0) begin fails++; $display("FAIL int_latency_early: got %b want 0", int_rx_host); end
    @(posedge clk); #1;
    tests++;
    if (int_rx_host !== 1'b1) begin fails++; $display("FAIL int_assert: got %b want 1", int_rx_host); end
    bus_read(8'hF0, d, ack);
    tests++;
    if (d !== 8'h01) begin fails++; $display("FAIL int_status: got %h want 01", d); end
    bus_read(8'h00, d, ack);
    #1;
    tests++;
    if (int_rx_host !== 1'b0) begin fails++; $display("FAIL int_deassert: got %b want 0", int_rx_host); end
    for (int i = 0; i < 3; i++) bus_read(8'h00, d, ack);
    bus_write(8'h03, 8'h01);
    bus_write(8'h02, 8'h00);
  endtask

  task automatic test_flush_ovf;
    logic [7:0] d; logic ack;
    for (int i = 0; i < 3; i++) push(1, 8'h50 + 8'(i));
    @(negedge clk);
    dec_valid[1] = 1'b1; dec_data[15:8] = 8'h5F;
    bus.valid = 1'b1; bus.write = 1'b1; bus.address = 8'h07; bus.data_in = 8'h05;
    @(posedge clk); #1;
    dec_valid = '0; bus.valid = 1'b0; bus.write = 1'b0;
    @(posedge clk);
    bus_read(8'h05, d, ack);
    tests++;
    if (d !== 8'h01) begin fails++; $display("FAIL flush_status: got %h want 01", d); end
    for (int i = 0; i < 16; i++) push(1, 8'h60 + 8'(i));
    @(negedge clk);
    dec_valid[1] = 1'b1; dec_data[15:8] = 8'h7F;
    bus.valid = 1'b1; bus.write = 1'b1; bus.address = 8'h07; bus.data_in = 8'h09;
    @(posedge clk); #1;
    dec_valid = '0; bus.valid = 1'b0; bus.write = 1'b0;
    @(posedge clk);
    bus_read(8'h05, d, ack);
    tests++;
    if (d !== 8'h86) begin fails++; $display("FAIL ovf_set_wins: got %h want 86", d); end
    bus_read(8'h04, d, ack);
    tests++;
    if (d !== 8'h60) begin fails++; $display("FAIL ovf_contents: got %h want 60", d); end
    bus_write(8'h07, 8'h0D);
    bus_read(8'h05, d, ack);
    tests++;
    if (d !== 8'h01) begin fails++; $display("FAIL flush_clr_status: got %h want 01", d); end
  endtask

  task automatic test_reset_mid_read;
    logic [7:0] d; logic ack;
    push(0, 8'hC1);
    push(0, 8'hC2);
    bus_read(8'h01, d, ack);
    @(negedge clk);
    bus.valid = 1'b1; bus.write = 1'b0; bus.address = 8'h00;
    #2 reset = 1'b0;
    @(posedge clk); #1;
    bus.valid = 1'b0;
    tests++;
    if (bus.ready !== 1'b0) begin fails++; $display("FAIL reset_abort_ready: got %b want 0", bus.ready); end
    @(posedge clk); #1;
    tests++;
    if ({bus.ready, bus.data_out} !== 9'h000) begin
      fails++; $display("FAIL reset_abort_out: got ready=%b data_out=%h want 0/00", bus.ready, bus.data_out);
    end
    @(negedge clk); reset = 1'b1;
    bus_read(8'h01, d, ack);
    tests++;
    if (d !== 8'h01) begin fails++; $display("FAIL reset_abort_empty: got %h want 01", d); end
  endtask

  initial begin
    bus.valid = 1'b0; bus.write = 1'b0; bus.address = '0; bus.data_in = '0;
    test_reset;
    test_bus_timing;
    test_fill_drain;
    test_wrap_simul;
    test_threshold;
    test_flush_ovf;
    test_reset_mid_read;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
